nr_recip_norm: RTL

//  Normalising Newton-Raphson reciprocal with valid/ready streaming and a sideband tag.

---
 rtl/nr_recip_pkg.sv | 27 ++
 rtl/nr_lzc.sv | 23 ++
 rtl/nr_recip_norm.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nr_recip_pkg.sv
// rtl/nr_recip_pkg.sv - state encoding and constant helpers shared by nr_recip_norm
package nr_recip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_SEED,
    ST_MUL_A,
    ST_MUL_B,
    ST_DENORM,
    ST_DONE
  } nr_state_t;

  localparam int     Q_DEFAULT = 26;
  localparam longint TWO_Q     = longint'(1) << (Q_DEFAULT + 1);

  // Reciprocal of the midpoint of mantissa interval idx, so the seed error is balanced
  function automatic longint seed_val(input int idx, input int q, input int lut_bits);
    return (longint'(1) << (q + lut_bits + 1)) /
           ((longint'(1) << (lut_bits + 1)) + longint'(2 * idx + 1));
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/nr_lzc.sv
// rtl/nr_lzc.sv - combinational MSB-position finder (index of highest set bit, zero flag)
module nr_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         a,
  output logic [$clog2(WIDTH)-1:0] msb_idx,
  output logic                     zero
);

  localparam int PW = $clog2(WIDTH);

  always_comb begin
    msb_idx = '0;
    zero    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) begin
        msb_idx = PW'(i);
        zero    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nr_recip_norm.sv
// rtl/nr_recip_norm.sv - normalising Newton-Raphson reciprocal, valid/ready stream with tag
// NR_RECIP_ROUND_EN: round half up on every internal right shift (default: truncate)
module nr_recip_norm
  import nr_recip_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int Q        = 26,
  parameter int LUT_BITS = 4,
  parameter int ITER     = 3,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             out_sat
);

  localparam int PW    = $clog2(WIDTH);
  localparam int SW    = PW + 2;
  localparam int IW    = $clog2(ITER + 1);
  localparam int DW    = 2 * WIDTH;
  localparam int NSEED = 1 << LUT_BITS;

`ifdef NR_RECIP_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam logic signed [WIDTH-1:0] TWO_Q_W   = WIDTH'(longint'(1) << (Q + 1));
  localparam logic        [WIDTH-1:0] SAT_MAX   = WIDTH'(sat_max(WIDTH));
  localparam logic        [DW-1:0]    SAT_MAX_W = DW'(SAT_MAX);
  localparam logic signed [DW-1:0]    RND_Q     = ROUND_EN ? (DW'(1) <<< (Q - 1)) : '0;

  typedef logic [NSEED-1:0][WIDTH-1:0] seed_tab_t;

  function automatic seed_tab_t build_seed_tab();
    seed_tab_t tab;
    for (int i = 0; i < NSEED; i++) tab[i] = WIDTH'(seed_val(i, Q, LUT_BITS));
    return tab;
  endfunction

  localparam seed_tab_t SEED_TAB = build_seed_tab();

  nr_state_t                state_q, state_d;
  logic [WIDTH-1:0]         a_q, a_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic signed [WIDTH-1:0]  m_q, m_d;
  logic signed [SW-1:0]     s_q, s_d;
  logic signed [WIDTH-1:0]  x_q, x_d;
  logic signed [WIDTH-1:0]  t_q, t_d;
  logic [IW-1:0]            iter_q, iter_d;
  logic                     bad_q, bad_d;
  logic [WIDTH-1:0]         y_q, y_d;
  logic                     err_q, err_d;
  logic                     sat_q, sat_d;

  logic [PW-1:0]            lzc_idx;
  logic                     lzc_zero;
  logic signed [WIDTH-1:0]  mul_op1, mul_op2, prod_sh;
  logic signed [DW-1:0]     prod;
  logic [LUT_BITS-1:0]      seed_idx;
  logic [SW-1:0]            sh_amt;
  logic [DW-1:0]            dn_xw, dn_rnd, dn_wide;
  logic                     dn_ovf, dn_sat;
  logic [WIDTH-1:0]         dn_y;

  nr_lzc #(.WIDTH(WIDTH)) u_lzc (
    .a       (a_q),
    .msb_idx (lzc_idx),
    .zero    (lzc_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_NORM;
      ST_NORM:   state_d = ST_SEED;
      ST_SEED:   state_d = ST_MUL_A;
      ST_MUL_A:  state_d = ST_MUL_B;
      ST_MUL_B:  state_d = (iter_q == IW'(ITER - 1)) ? ST_DENORM : ST_MUL_A;
      ST_DENORM: state_d = ST_DONE;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // One shared multiplier: m*x in MUL_A, x*(2-t) in MUL_B
  always_comb begin
    mul_op1 = x_q;
    mul_op2 = TWO_Q_W - t_q;
    if (state_q == ST_MUL_A) begin
      mul_op1 = m_q;
      mul_op2 = x_q;
    end
    prod    = DW'(mul_op1) * DW'(mul_op2);
    prod_sh = WIDTH'((prod + RND_Q) >>> Q);
  end

  assign seed_idx = m_q[Q-1 -: LUT_BITS];

  // Undo the normalisation; x is positive so the shift runs on a zero-extended copy
  always_comb begin
    sh_amt  = s_q[SW-1] ? SW'(-s_q) : SW'(s_q);
    dn_xw   = {{WIDTH{1'b0}}, x_q};
    dn_rnd  = '0;
    dn_ovf  = 1'b0;
    if (!s_q[SW-1]) begin
      if (ROUND_EN && sh_amt != '0) dn_rnd = DW'(1) << (sh_amt - SW'(1));
      dn_wide = (int'(sh_amt) >= WIDTH) ? '0 : ((dn_xw + dn_rnd) >> sh_amt);
    end else begin
      dn_ovf  = (int'(sh_amt) >= WIDTH);
      dn_wide = dn_xw << sh_amt;
    end
    dn_sat = dn_ovf || (dn_wide > SAT_MAX_W);
    dn_y   = dn_sat ? SAT_MAX : WIDTH'(dn_wide);
  end

  always_comb begin
    a_d    = a_q;
    tag_d  = tag_q;
    m_d    = m_q;
    s_d    = s_q;
    x_d    = x_q;
    t_d    = t_q;
    iter_d = iter_q;
    bad_d  = bad_q;
    y_d    = y_q;
    err_d  = err_q;
    sat_d  = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = a_in;
          tag_d = in_tag;
        end
      end
      ST_NORM: begin
        bad_d  = a_q[WIDTH-1] | lzc_zero;
        iter_d = '0;
        m_d    = '0;
        s_d    = '0;
        if (!(a_q[WIDTH-1] | lzc_zero)) begin
          if (int'(lzc_idx) >= Q) m_d = $signed(a_q >> (int'(lzc_idx) - Q));
          else                    m_d = $signed(a_q << (Q - int'(lzc_idx)));
          s_d = SW'(int'(lzc_idx) - Q);
        end
      end
      ST_SEED:  x_d = bad_q ? '0 : $signed(SEED_TAB[seed_idx]);
      ST_MUL_A: if (!bad_q) t_d = prod_sh;
      ST_MUL_B: begin
        if (!bad_q) x_d = prod_sh;
        iter_d = iter_q + IW'(1);
      end
      ST_DENORM: begin
        y_d   = bad_q ? SAT_MAX : dn_y;
        err_d = bad_q;
        sat_d = !bad_q && dn_sat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      tag_q  <= '0;
      m_q    <= '0;
      s_q    <= '0;
      x_q    <= '0;
      t_q    <= '0;
      iter_q <= '0;
      bad_q  <= 1'b0;
      y_q    <= '0;
      err_q  <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      tag_q  <= tag_d;
      m_q    <= m_d;
      s_q    <= s_d;
      x_q    <= x_d;
      t_q    <= t_d;
      iter_q <= iter_d;
      bad_q  <= bad_d;
      y_q    <= y_d;
      err_q  <= err_d;
      sat_q  <= sat_d;
    end
  end

  assign y_out   = y_q;
  assign out_tag = tag_q;
  assign out_err = err_q;
  assign out_sat = sat_q;

endmodule
